// File: rtl/led_sequence_player_if.sv
// Control, sequence-write, pattern and status signals of the LED sequence player.
interface led_sequence_player_if;
    logic       start;
    logic       abort;
    logic [4:0] length;
    logic       seq_wr_en;
    logic [3:0] seq_wr_addr;
    logic [1:0] seq_wr_data;
    logic [7:0] pat0;
    logic [7:0] pat1;
    logic [7:0] pat2;
    logic [7:0] pat3;
    logic [7:0] led;
    logic       busy;
    logic       done;
    logic [3:0] step;

    modport master (
        output start, abort, length, seq_wr_en, seq_wr_addr, seq_wr_data,
        output pat0, pat1, pat2, pat3,
        input  led, busy, done, step
    );

    modport slave (
        input  start, abort, length, seq_wr_en, seq_wr_addr, seq_wr_data,
        input  pat0, pat1, pat2, pat3,
        output led, busy, done, step
    );
endinterface

// File: rtl/led_sequence_player.sv
// Plays a stored sequence of 2-bit pattern indices as timed LED flashes with a
// blank gap between steps, pulsing done when the sequence has been shown.
module led_sequence_player #(
    parameter int unsigned SEQ_MAX    = 16,
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 12500000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_sequence_player_if.slave  bus
);

    localparam int unsigned AW = 4;
    localparam int unsigned LW = 5;
    localparam int unsigned PW = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHOW   = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]  len_q, len_d;
    logic [AW-1:0]  step_q, step_d;
    logic [PW-1:0]  led_q, led_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [1:0]     mem_q [SEQ_MAX];
    logic [PW-1:0]  pat_tbl [4];
    logic           wr_ok;
    logic [1:0]     first_idx;
    logic [AW-1:0]  step_nxt;
    logic [LW-1:0]  len_clamped;

    assign pat_tbl[0] = bus.pat0;
    assign pat_tbl[1] = bus.pat1;
    assign pat_tbl[2] = bus.pat2;
    assign pat_tbl[3] = bus.pat3;

    assign wr_ok       = (state_q == IDLE) && bus.seq_wr_en;
    assign step_nxt    = step_q + AW'(1);
    assign len_clamped = (bus.length > LW'(SEQ_MAX)) ? LW'(SEQ_MAX) : bus.length;
    // A same-cycle write to entry 0 must be visible to the first step shown.
    assign first_idx   = (wr_ok && (bus.seq_wr_addr == '0)) ? bus.seq_wr_data : mem_q[0];

    // Sequence memory; intentionally not reset so a stored game survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[bus.seq_wr_addr] <= bus.seq_wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        step_d  = step_q;
        led_d   = led_q;

        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            led_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    led_d = '0;
                    if (bus.start) begin
                        step_d = '0;
                        cnt_d  = '0;
                        if (len_clamped == '0) begin
                            state_d = FINISH;
                        end else begin
                            len_d   = len_clamped;
                            led_d   = pat_tbl[first_idx];
                            state_d = SHOW;
                        end
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
                        cnt_d   = '0;
                        led_d   = '0;
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(OFF_CYCLES - 1)) begin
                        cnt_d = '0;
                        if ({1'b0, step_q} == (len_q - LW'(1))) begin
                            state_d = FINISH;
                        end else begin
                            step_d  = step_nxt;
                            led_d   = pat_tbl[mem_q[step_nxt]];
                            state_d = SHOW;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    led_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == SHOW) || (state_d == GAP);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            step_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            step_q  <= step_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.step = step_q;

endmodule

// File: doc/led_sequence_player.md
Name: led_sequence_player

Overview:
- Plays a stored sequence of 8-bit LED patterns for the memory game.
- Consumes the constant pattern generators (con0..con3 family): each one drives one pattern input port.
- Shows each sequence step for a fixed on-time, then blanks for a fixed gap, then advances.
- Signals done when the sequence ends, so the game FSM can move to the player-input phase.

Parameters:
- SEQ_MAX, 16: sequence memory depth (entries); power of two.
- ON_CYCLES, 25000000: clock cycles each pattern is displayed; must be >= 1.
- OFF_CYCLES, 12500000: clock cycles of blank (led=0) after each pattern; must be >= 1.
- CNT_W, 25: width of the dwell counter; must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin playback; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE, led=0, no done pulse
- length  input  5  number of steps to play, 0..16; values >16 are clamped to 16
- seq_wr_en  input  1  write one sequence entry; ignored while busy
- seq_wr_addr  input  4  entry address
- seq_wr_data  input  2  pattern index 0..3 for that entry
- pat0  input  8  pattern for index 0 (from con0)
- pat1  input  8  pattern for index 1
- pat2  input  8  pattern for index 2
- pat3  input  8  pattern for index 3
- led  output  8  registered LED drive
- busy  output  1  high in SHOW and GAP
- done  output  1  one-cycle pulse at end of playback
- step  output  4  index of the entry currently shown/last shown

Behaviour:
- Reset (rst_n=0, asynchronous):
  - led=0, busy=0, done=0, step=0, state=IDLE, dwell counter=0, captured length=0.
  - Sequence memory contents are not reset.
- FSM states: IDLE, SHOW, GAP, FINISH.
- IDLE:
  - led=0, busy=0.
  - seq_wr_en writes mem[seq_wr_addr]=seq_wr_data at the clock edge.
  - start=1 with length>=1: capture min(length,16) as len_q, step=0, counter=0, enter SHOW. At the same edge, led <= pat[mem[0]].
  - If seq_wr_en and start are asserted in the same cycle, the write completes first and entry 0 reflects the new value.
  - start=1 with length=0: enter FINISH, no pattern shown.
- SHOW:
  - led holds the pattern latched on entry; later pat* changes are not reflected.
  - The counter increments each cycle. After exactly ON_CYCLES cycles in SHOW: led <= 0, counter=0, enter GAP.
- GAP:
  - led=0 for exactly OFF_CYCLES cycles.
  - Then, if step == len_q-1: enter FINISH.
  - Otherwise: step <= step+1, led <= pat[mem[step+1]], enter SHOW.
  - step never wraps beyond len_q-1.
- FINISH:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - step retains its final value until the next start.
- busy=1 exactly while in SHOW or GAP.
- start asserted while busy or in FINISH is ignored; it is not queued.
- seq_wr_en while busy is ignored; memory is unchanged.
- abort:
  - Highest priority after reset, in any state: next edge led=0, busy=0, state=IDLE, counter=0, no done pulse.
  - abort and start in the same IDLE cycle: abort wins, no playback.
- Consecutive identical entries are separated by the blank GAP, so the player sees distinct flashes.
- Total playback time from the start edge to the done pulse: len_q*(ON_CYCLES+OFF_CYCLES) cycles, with done high in the following cycle.

Test Plan:
Bench parameters: ON_CYCLES=4, OFF_CYCLES=2, pat0=8'h00, pat1=8'h0F, pat2=8'hF0, pat3=8'hFF.
- Reset mid-SHOW: assert rst_n=0 asynchronously -> led=00, busy=0, step=0 immediately, without waiting for a clock edge; memory contents are preserved and replay identically afterwards.
- mem[0..2]={1,2,3}, length=3, start pulse -> led shows 0F for 4 cycles, then 00 for 2, F0 for 4, 00 for 2, FF for 4, 00 for 2; done high 1 cycle, 18 cycles after the start edge; step ends at 2.
- length=0, start -> no nonzero led, busy stays 0, done pulses on the cycle after start.
- length=20 with mem all =3 -> exactly 16 FF flashes, step ends at 15, done once.
- During playback, pulse start and write mem[0]=0 -> playback unaffected, mem[0] unchanged. Repeat playback -> identical led trace.
- abort asserted on 3rd cycle of the second SHOW -> led=00 next cycle, busy=0, no done; then a new start replays from step 0.
